l2_lookup_sched: RTL and testbench

//  Sequences the shared L2 tag/state lookup path: arbitrates CPU requests (req) and

---
 rtl/l2_lookup_sched_if.sv | 51 +++++
 rtl/l2_lookup_sched.sv | 121 ++++++++++++
 tb/tb_l2_lookup_sched.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_lookup_sched_if.sv
// Port bundle for the L2 tag/state lookup scheduler.
// master = requesters, array, lookup stage and rsp consumer; slave = scheduler.
interface l2_lookup_sched_if #(
  parameter int SET_W = 9,
  parameter int TAG_W = 19,
  parameter int WAY_W = 3
);
  logic             req_valid;
  logic [SET_W-1:0] req_set;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready;
  logic             fwd_valid;
  logic [SET_W-1:0] fwd_set;
  logic [TAG_W-1:0] fwd_tag;
  logic             fwd_ready;
  logic             req_set_busy;
  logic             rd_en;
  logic [SET_W-1:0] rd_set;
  logic             lookup_en;
  logic             lookup_mode;
  logic [TAG_W-1:0] lookup_tag;
  logic             tag_hit;
  logic [WAY_W-1:0] way_hit;
  logic             empty_way_found;
  logic [WAY_W-1:0] empty_way;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_src;
  logic [SET_W-1:0] rsp_set;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_hit;
  logic [WAY_W-1:0] rsp_way;
  logic             rsp_empty_found;
  logic [WAY_W-1:0] rsp_empty_way;

  modport master (
    output req_valid, req_set, req_tag, fwd_valid, fwd_set, fwd_tag, req_set_busy,
           tag_hit, way_hit, empty_way_found, empty_way, rsp_ready,
    input  req_ready, fwd_ready, rd_en, rd_set, lookup_en, lookup_mode, lookup_tag,
           rsp_valid, rsp_src, rsp_set, rsp_tag, rsp_hit, rsp_way,
           rsp_empty_found, rsp_empty_way
  );

  modport slave (
    input  req_valid, req_set, req_tag, fwd_valid, fwd_set, fwd_tag, req_set_busy,
           tag_hit, way_hit, empty_way_found, empty_way, rsp_ready,
    output req_ready, fwd_ready, rd_en, rd_set, lookup_en, lookup_mode, lookup_tag,
           rsp_valid, rsp_src, rsp_set, rsp_tag, rsp_hit, rsp_way,
           rsp_empty_found, rsp_empty_way
  );
endinterface

// File: rtl/l2_lookup_sched.sv
// L2 lookup scheduler: arbitrates req/fwd, sequences array read and lookup stage,
// and returns the captured lookup result over a valid/ready port. One lookup in flight.
//
//  state  | meaning
//  IDLE   | waiting for an eligible req/fwd; grant, read strobe and capture happen here
//  RD     | waiting out the tag/state array read latency
//  LOOKUP | one-cycle lookup_en pulse to the lookup stage
//  RESP   | result presented on rsp_*, held until rsp_ready
module l2_lookup_sched #(
  parameter int SET_W      = 9,
  parameter int TAG_W      = 19,
  parameter int WAY_W      = 3,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  l2_lookup_sched_if.slave bus
);

  localparam int CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD, LOOKUP, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rd_cnt_q;
  logic [STARVE_W-1:0] starve_q;
  logic                grant_req, grant_fwd;
  logic                req_elig, fwd_elig;
  logic                cap_src;
  logic [SET_W-1:0]    cap_set;
  logic [TAG_W-1:0]    cap_tag;
  logic                first_q;
  logic                resp_first;
  logic                hold_hit, hold_empty_found;
  logic [WAY_W-1:0]    hold_way, hold_empty_way;

  assign req_elig = bus.req_valid && !bus.req_set_busy;
  assign fwd_elig = bus.fwd_valid;

  always_comb begin
    state_d   = state_q;
    grant_req = 1'b0;
    grant_fwd = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Grants are combinational, so they are masked while reset is held.
        if (!rst) begin
          if (req_elig && (!fwd_elig || starve_q == STARVE_W'(STARVE_MAX)))
            grant_req = 1'b1;
          else if (fwd_elig)
            grant_fwd = 1'b1;
        end
        if (grant_req || grant_fwd) state_d = RD;
      end
      RD:      if (rd_cnt_q == '0) state_d = LOOKUP;
      LOOKUP:  state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      rd_cnt_q         <= '0;
      starve_q         <= '0;
      cap_src          <= 1'b0;
      cap_set          <= '0;
      cap_tag          <= '0;
      first_q          <= 1'b0;
      hold_hit         <= 1'b0;
      hold_way         <= '0;
      hold_empty_found <= 1'b0;
      hold_empty_way   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_q == LOOKUP);
      if (grant_req || grant_fwd) begin
        cap_src  <= grant_fwd;
        cap_set  <= grant_req ? bus.req_set : bus.fwd_set;
        cap_tag  <= grant_req ? bus.req_tag : bus.fwd_tag;
        rd_cnt_q <= CNT_W'(RD_LAT - 1);
      end else if (state_q == RD && rd_cnt_q != '0) begin
        rd_cnt_q <= rd_cnt_q - 1'b1;
      end
      if (grant_req)
        starve_q <= '0;
      else if (grant_fwd && req_elig && starve_q != STARVE_W'(STARVE_MAX))
        starve_q <= starve_q + 1'b1;
      if (resp_first) begin
        hold_hit         <= bus.tag_hit;
        hold_way         <= bus.way_hit;
        hold_empty_found <= bus.empty_way_found;
        hold_empty_way   <= bus.empty_way;
      end
    end
  end

  // The lookup stage registers its result on lookup_en, so it is only valid from the
  // first RESP cycle on: pass it through then, and hold the sampled copy afterwards.
  assign resp_first = (state_q == RESP) && first_q;

  assign bus.req_ready       = grant_req;
  assign bus.fwd_ready       = grant_fwd;
  assign bus.rd_en           = grant_req || grant_fwd;
  assign bus.rd_set          = grant_req ? bus.req_set : (grant_fwd ? bus.fwd_set : '0);
  assign bus.lookup_en       = (state_q == LOOKUP);
  assign bus.lookup_mode     = (state_q == LOOKUP) && cap_src;
  assign bus.lookup_tag      = (state_q == LOOKUP) ? cap_tag : '0;
  assign bus.rsp_valid       = (state_q == RESP);
  assign bus.rsp_src         = cap_src;
  assign bus.rsp_set         = cap_set;
  assign bus.rsp_tag         = cap_tag;
  assign bus.rsp_hit         = resp_first ? bus.tag_hit : hold_hit;
  assign bus.rsp_way         = resp_first ? bus.way_hit : hold_way;
  assign bus.rsp_empty_found = resp_first ? bus.empty_way_found : hold_empty_found;
  assign bus.rsp_empty_way   = resp_first ? bus.empty_way : hold_empty_way;

endmodule

// File: tb/tb_l2_lookup_sched.sv
// Directed bench for l2_lookup_sched: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares them on each rsp handshake.
module tb_l2_lookup_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scramble = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  l2_lookup_sched_if #(.SET_W(9), .TAG_W(19), .WAY_W(3)) bus ();

  l2_lookup_sched #(
    .SET_W(9), .TAG_W(19), .WAY_W(3), .RD_LAT(1), .STARVE_MAX(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        src;
    logic [8:0]  set;
    logic [18:0] tag;
    logic        hit;
    logic [2:0]  way;
    logic        ef;
    logic [2:0]  ew;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic src, input logic [8:0] set, input logic [18:0] tag,
                      input logic hit, input logic [2:0] way, input logic ef,
                      input logic [2:0] ew);
    exp_t e;
    e.src = src; e.set = set; e.tag = tag; e.hit = hit; e.way = way; e.ef = ef; e.ew = ew;
    exp_q.push_back(e);
  endtask

  // Lookup stage model: hit=tag[0], way=tag[3:1]; empty fields only for req lookups.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tag_hit         <= 1'b0;
      bus.way_hit         <= '0;
      bus.empty_way_found <= 1'b0;
      bus.empty_way       <= '0;
    end else if (bus.lookup_en) begin
      bus.tag_hit         <= bus.lookup_tag[0];
      bus.way_hit         <= bus.lookup_tag[3:1];
      bus.empty_way_found <= !bus.lookup_mode && !bus.lookup_tag[0];
      bus.empty_way       <= bus.lookup_mode ? 3'd0 : bus.lookup_tag[6:4];
    end else if (scramble) begin
      bus.tag_hit         <= ~bus.tag_hit;
      bus.way_hit         <= bus.way_hit + 3'd1;
      bus.empty_way_found <= ~bus.empty_way_found;
      bus.empty_way       <= bus.empty_way + 3'd3;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_src", 32'(bus.rsp_src), 32'(e.src));
        check("rsp_set", 32'(bus.rsp_set), 32'(e.set));
        check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
        check("rsp_hit", 32'(bus.rsp_hit), 32'(e.hit));
        check("rsp_way", 32'(bus.rsp_way), 32'(e.way));
        check("rsp_empty_found", 32'(bus.rsp_empty_found), 32'(e.ef));
        check("rsp_empty_way", 32'(bus.rsp_empty_way), 32'(e.ew));
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    check({name, "_strobes"},
          32'({bus.req_ready, bus.fwd_ready, bus.rd_en, bus.lookup_en, bus.rsp_valid}), 32'd0);
    check({name, "_rd_set"}, 32'(bus.rd_set), 32'd0);
    check({name, "_lookup"}, 32'({bus.lookup_mode, bus.lookup_tag}), 32'd0);
    check({name, "_rsp"}, 32'({bus.rsp_src, bus.rsp_hit, bus.rsp_way,
                               bus.rsp_empty_found, bus.rsp_empty_way}), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns at posedge+1 once all expected responses have been consumed.
  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("wait_empty_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_req_ready(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < budget);
    check("req_ready_seen", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_set = '0; bus.req_tag = '0;
    bus.fwd_valid = 0; bus.fwd_set = '0; bus.fwd_tag = '0;
    bus.req_set_busy = 0; bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single req, hit way 3, exact cycle timing
    bus.req_valid = 1; bus.req_set = 9'h005; bus.req_tag = 19'h01237;
    push(0, 9'h005, 19'h01237, 1, 3'd3, 0, 3'd3);
    @(negedge clk);
    check("t1_req_ready_c0", 32'(bus.req_ready), 32'd1);
    check("t1_rd_en_c0", 32'(bus.rd_en), 32'd1);
    check("t1_rd_set_c0", 32'(bus.rd_set), 32'h005);
    @(posedge clk); #1;
    bus.req_valid = 0;
    @(negedge clk);
    check("t1_quiet_c1", 32'({bus.req_ready, bus.rd_en, bus.lookup_en, bus.rsp_valid}), 32'd0);
    @(negedge clk);
    check("t1_lookup_en_c2", 32'(bus.lookup_en), 32'd1);
    check("t1_lookup_mode_c2", 32'(bus.lookup_mode), 32'd0);
    check("t1_lookup_tag_c2", 32'(bus.lookup_tag), 32'h01237);
    check("t1_rsp_valid_c2", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_rsp_valid_c3", 32'(bus.rsp_valid), 32'd1);
    wait_empty(20);

    // 2: req and fwd together -> fwd first, req right after
    bus.fwd_valid = 1; bus.fwd_set = 9'h1A0; bus.fwd_tag = 19'h0ABC5;
    bus.req_valid = 1; bus.req_set = 9'h033; bus.req_tag = 19'h00040;
    push(1, 9'h1A0, 19'h0ABC5, 1, 3'd2, 0, 3'd0);
    push(0, 9'h033, 19'h00040, 0, 3'd0, 1, 3'd4);
    @(negedge clk);
    check("t2_fwd_ready", 32'(bus.fwd_ready), 32'd1);
    check("t2_req_ready", 32'(bus.req_ready), 32'd0);
    check("t2_rd_set", 32'(bus.rd_set), 32'h1A0);
    @(posedge clk); #1;
    bus.fwd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("t2_lookup_mode", 32'({bus.lookup_en, bus.lookup_mode}), 32'd3);
    wait_req_ready(20);
    wait_empty(20);

    // 3: continuous contention -> F,F,F,F,R,F,F,F,F,R
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) push(0, 9'h033, 19'h00040, 0, 3'd0, 1, 3'd4);
      else                  push(1, 9'h1A0, 19'h0ABC5, 1, 3'd2, 0, 3'd0);
    end
    bus.fwd_valid = 1; bus.req_valid = 1;
    wait_empty(200);
    bus.fwd_valid = 0; bus.req_valid = 0;
    @(negedge clk);
    check("t3_no_extra_grant", 32'({bus.req_ready, bus.fwd_ready}), 32'd0);

    // 4: busy set blocks req, no grant until busy drops
    do_reset();
    bus.req_valid = 1; bus.req_set = 9'h101; bus.req_tag = 19'h7FFFF;
    bus.req_set_busy = 1;
    push(0, 9'h101, 19'h7FFFF, 1, 3'd7, 0, 3'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_blocked", 32'({bus.req_ready, bus.rd_en}), 32'd0);
    end
    @(posedge clk); #1;
    bus.req_set_busy = 0;
    @(negedge clk);
    check("t4_req_ready", 32'(bus.req_ready), 32'd1);
    check("t4_rd_set", 32'(bus.rd_set), 32'h101);
    @(posedge clk); #1;
    bus.req_valid = 0;
    wait_empty(20);

    // 5: rsp stall with toggling lookup-stage outputs
    bus.rsp_ready = 0;
    bus.req_valid = 1; bus.req_set = 9'h0FF; bus.req_tag = 19'h0002B;
    push(0, 9'h0FF, 19'h0002B, 1, 3'd5, 0, 3'd2);
    wait_req_ready(5);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.rsp_valid && n < 10);
    end
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    scramble = 1;
    bus.fwd_valid = 1; bus.fwd_set = 9'h1A0; bus.fwd_tag = 19'h0ABC5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("t5_hold_hit_way", 32'({bus.rsp_hit, bus.rsp_way}), 32'({1'b1, 3'd5}));
      check("t5_hold_empty", 32'({bus.rsp_empty_found, bus.rsp_empty_way}), 32'({1'b0, 3'd2}));
      check("t5_no_grant", 32'({bus.req_ready, bus.fwd_ready, bus.rd_en}), 32'd0);
    end
    @(posedge clk); #1;
    bus.fwd_valid = 0; scramble = 0; bus.rsp_ready = 1;
    wait_empty(10);

    // 6: async reset during LOOKUP aborts; pending req is granted afresh
    bus.req_valid = 1; bus.req_set = 9'h077; bus.req_tag = 19'h12345;
    @(negedge clk);
    check("t6_first_grant", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("t6_in_lookup", 32'(bus.lookup_en), 32'd1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("t6_async");
    @(posedge clk); #1;
    check_idle_outputs("t6_held");
    rst = 1'b0;
    push(0, 9'h077, 19'h12345, 1, 3'd2, 0, 3'd4);
    @(negedge clk);
    check("t6_regrant", 32'(bus.req_ready), 32'd1);
    check("t6_regrant_set", 32'(bus.rd_set), 32'h077);
    @(posedge clk); #1;
    bus.req_valid = 0;
    wait_empty(20);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
